main_mem_responder: RTL and testbench
=====================================

# main_mem_responder

Memory-side responder for the cache-controller-to-memory interface: accepts 128-bit line read/write requests (`mem_req_type`), services them from an internal line array after a fixed latency, and returns `mem_data_type` with a one-cycle `ready` pulse. It sits below the cache controller as the backing store in simulation and FPGA builds, and pairs with the controller's request FSM.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `ready` pulse; legal range ≥1.
- `MEM_LINES`, 1024: number of 128-bit lines stored; power of two.
- `clk`  input  1  system clock, all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `mem_req`  input  `mem_req_type` (32+128+1+1)  request from cache controller: `addr`, `data`, `rw` (0 read / 1 write), `valid`.
- `mem_data`  output  `mem_data_type` (128+1)  response: `data`, `ready`.
- `rd_count`  output  32  completed reads (stats, see Configuration).
- `wr_count`  output  32  completed writes (stats, see Configuration).

## Operation
- Line index = `addr[$clog2(MEM_LINES)+3:4]`; `addr[3:0]` ignored; higher address bits alias (wrap modulo `MEM_LINES`).
- FSM states: IDLE, BUSY, RESP.
  - IDLE: if `mem_req.valid`=1, latch `addr`, `data`, `rw`; load counter with `LATENCY-1`; go BUSY (or RESP directly when `LATENCY`=1).
  - BUSY: decrement counter; at 0 go RESP.
  - RESP: `mem_data.ready`=1 for this cycle only; go IDLE.
- Read: in RESP, `mem_data.data` = array line at latched index (value at response time).
- Write: latched data committed to array on the RESP cycle edge; `mem_data.data` echoes the written line.
- `mem_data.data` = 0 whenever `ready`=0.
- Request fields sampled only in IDLE; changes to `mem_req` during BUSY/RESP are ignored.
- Requester keeps `valid` high until it sees `ready`; `valid` dropping mid-BUSY does not cancel the transaction.
- `valid` still high in the first IDLE after RESP is treated as a new request (back-to-back write-back then allocate).
- Array contents are not reset.

## Timing
- Request accepted at IDLE edge T with `valid`=1 → `ready`=1 during cycle T+`LATENCY`.
- Minimum request-to-request spacing: `LATENCY`+1 cycles (one IDLE cycle after each RESP).
- `ready` and `data` registered outputs; no combinational path from `mem_req` to `mem_data`.
- Reset values: state IDLE, `mem_data.ready`=0, `mem_data.data`=0, counter 0, `rd_count`=0, `wr_count`=0.
- Reset asserted mid-transaction: FSM to IDLE immediately, no `ready` pulse, pending write discarded (array unchanged); after release, next `valid` starts a fresh transaction.

## Configuration
- `MEM_STATS_EN` defined: `rd_count`/`wr_count` increment by 1 on each RESP cycle of a read/write respectively; saturate at 32'hFFFF_FFFF; reset to 0.
- `MEM_STATS_EN` undefined: counters not built; `rd_count`, `wr_count` tied to 0.

## Structure
- Add to `cache_pkg`: `MEM_LATENCY` (4), `MEM_LINES` (1024) constants, `mem_state_type` enum {IDLE, BUSY, RESP}; reuse existing `mem_req_type`, `mem_data_type`, `cache_data_type`.
- One sub-module: `mem_line_array` — `MEM_LINES` × `cache_data_type`, one combinational read port, one synchronous write port; no reset.

## Test plan
- Read after reset, `LATENCY`=4: write 128'hDEAD…0001 to addr 32'h0000_0010, then read 32'h0000_0010 → `ready` exactly 4 cycles after acceptance, `data`=128'hDEAD…0001, `ready` high one cycle.
- Alias/offset: write line at 32'h0000_0020, read 32'h0000_402C (`MEM_LINES`=1024) → same line returned.
- Back-to-back: `valid` held high, write to 0x30 then read 0x40 on the first IDLE → two `ready` pulses 5 cycles apart, correct data each.
- Ignore mid-flight changes: change `addr`/`rw` during BUSY → response reflects latched request only.
- Reset mid-write: assert `rst` in BUSY of write to 0x50 (old value 0) → no `ready`; later read of 0x50 returns 0.
- Stats (`MEM_STATS_EN`): 3 reads + 2 writes → `rd_count`=3, `wr_count`=2; without macro both read 0.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache/memory interface types and memory responder constants
package cache_pkg;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;     // 0 read, 1 write
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  localparam int MEM_LATENCY = 4;
  localparam int MEM_LINES   = 1024;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_type;

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - line storage, one combinational read port, one synchronous write port
module mem_line_array
  import cache_pkg::*;
#(
  parameter int LINES = 1024,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  cache_data_type   wdata,
  input  logic [IDX_W-1:0] raddr,
  output cache_data_type   rdata
);

  cache_data_type mem [LINES];

  // Line write; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - fixed-latency line memory responder; MEM_STATS_EN adds read/write counters
module main_mem_responder
  import cache_pkg::*;
#(
  parameter int LATENCY   = MEM_LATENCY,
  parameter int MEM_LINES = cache_pkg::MEM_LINES
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_type    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, resp_load, commit;

  logic [IDX_W-1:0] req_idx, lat_idx, rd_idx;
  cache_data_type   lat_data, rd_line, src_data, resp_line, data_q;
  logic             lat_rw, src_rw, ready_q;
  logic             unused_addr_bits;

  // Offset bits and bits above the index only alias onto the same line.
  assign req_idx          = mem_req.addr[IDX_W+3:4];
  assign unused_addr_bits = ^{mem_req.addr[31:IDX_W+4], mem_req.addr[3:0]};

  // In IDLE the response source is the live request (only used when LATENCY is 1);
  // otherwise it is the latched request.
  assign rd_idx    = (state == IDLE) ? req_idx      : lat_idx;
  assign src_rw    = (state == IDLE) ? mem_req.rw   : lat_rw;
  assign src_data  = (state == IDLE) ? mem_req.data : lat_data;
  assign resp_line = src_rw ? src_data : rd_line;

  // Write lands on the edge that ends RESP; a reset in that cycle discards it.
  assign commit = (state == RESP) && lat_rw && !rst;

  mem_line_array #(
    .LINES (MEM_LINES),
    .IDX_W (IDX_W)
  ) u_lines (
    .clk   (clk),
    .we    (commit),
    .waddr (lat_idx),
    .wdata (lat_data),
    .raddr (rd_idx),
    .rdata (rd_line)
  );

  // Next state and latency counter; counter reaching zero hands over to RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    resp_load = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req.valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            resp_load = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt = RESP;
          resp_load = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request fields are captured once, on acceptance, and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_idx  <= '0;
      lat_data <= '0;
      lat_rw   <= 1'b0;
    end else if (accept) begin
      lat_idx  <= req_idx;
      lat_data <= mem_req.data;
      lat_rw   <= mem_req.rw;
    end
  end

  // Registered response: data is driven only during the single ready cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      ready_q <= resp_load;
      data_q  <= resp_load ? resp_line : '0;
    end
  end

  assign mem_data.data  = data_q;
  assign mem_data.ready = ready_q;

`ifdef MEM_STATS_EN
  logic [31:0] rd_q, wr_q;

  // Completed-transaction counters, saturating, stepped on the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
    end else if (state == RESP) begin
      if (lat_rw) begin
        if (wr_q != 32'hFFFF_FFFF) wr_q <= wr_q + 32'd1;
      end else begin
        if (rd_q != 32'hFFFF_FFFF) rd_q <= rd_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_q;
  assign wr_count = wr_q;
`else
  assign rd_count = 32'd0;
  assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - randomized, model-checked bench for main_mem_responder
module tb_main_mem_responder;
  import cache_pkg::*;

  localparam int L     = 4;
  localparam int LINES = 1024;
  localparam cache_data_type DEAD = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  mem_req_type  req;
  mem_data_type resp;
  logic [31:0]  rd_count, wr_count;

  always #5 clk = ~clk;

  main_mem_responder #(.LATENCY(L), .MEM_LINES(LINES)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (req),
    .mem_data (resp),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Timeline model: a request seen at an idle edge e is answered during the cycle
  // after edge e+L-1, retired at edge e+L, and the next request can land at e+L+1.
  cache_data_type mm [LINES];
  int             edge_n  = 0;
  bit             pend    = 0;
  int             resp_edge = 0;
  int             free_at = 0;
  bit             p_rw;
  int             p_idx;
  cache_data_type p_val;
  int unsigned    m_rd = 0, m_wr = 0;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      pend = 0; free_at = 0; m_rd = 0; m_wr = 0;
    end else begin
      if (pend && edge_n == resp_edge + 1) begin
        if (p_rw) begin mm[p_idx] = p_val; m_wr++; end
        else m_rd++;
        pend = 0;
      end
      if (req.valid && edge_n >= free_at) begin
        p_idx     = int'((req.addr >> 4) % LINES);
        p_rw      = req.rw;
        p_val     = req.rw ? req.data : mm[p_idx];
        resp_edge = edge_n + L - 1;
        free_at   = edge_n + L + 1;
        pend      = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic e_ready;
    if (edge_n > 0) begin
      e_ready = pend && (edge_n == resp_edge) && !rst;
      check("ready", {127'd0, resp.ready}, {127'd0, e_ready});
      check("data", resp.data, e_ready ? p_val : '0);
`ifdef MEM_STATS_EN
      check("rd_count", {96'd0, rd_count}, {96'd0, m_rd});
      check("wr_count", {96'd0, wr_count}, {96'd0, m_wr});
`else
      check("rd_count", {96'd0, rd_count}, 128'd0);
      check("wr_count", {96'd0, wr_count}, 128'd0);
`endif
    end
  end

  // Called at a falling edge; returns at the falling edge where ready is seen, valid left high.
  task automatic do_req(input logic [31:0] a, input cache_data_type d, input logic rw,
                        input bit perturb, output cache_data_type got, output int waited);
    #1;
    req.addr = a; req.data = d; req.rw = rw; req.valid = 1'b1;
    waited = 0;
    got = '0;
    forever begin
      @(negedge clk);
      waited++;
      if (resp.ready) begin
        got = resp.data;
        break;
      end
      if (waited > 40) begin
        check("timeout", 128'(waited), 128'd0);
        break;
      end
      if (perturb && waited == 2) begin
        #1;
        req.addr = $urandom;
        req.rw   = ~req.rw;
        req.data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic idle(input int n);
    #1;
    req.valid = 1'b0;
    req.addr  = $urandom;
    req.rw    = 1'($urandom);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cache_data_type got, val;
    int w;
    logic [31:0] a;

    req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {127'd0, resp.ready}, 128'd0);
    check("rst_data", resp.data, 128'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Write then read back after reset, with latency and single-cycle pulse.
    do_req(32'h0000_0010, DEAD, 1'b1, 0, got, w);
    check("t1_wr_lat", 128'(w), 128'(L));
    check("t1_wr_echo", got, DEAD);
    idle(1);
    check("t1_pulse_wr", {127'd0, resp.ready}, 128'd0);
    do_req(32'h0000_0010, 128'h1234, 1'b0, 0, got, w);
    check("t1_rd_lat", 128'(w), 128'(L));
    check("t1_rd_data", got, DEAD);
    idle(1);
    check("t1_pulse_rd", {127'd0, resp.ready}, 128'd0);

    // Known contents for the lines the rest of the bench uses.
    for (int i = 0; i < 16; i++) begin
      do_req(32'(i) << 4, '0, 1'b1, 0, got, w);
      idle(1);
    end

    // Alias and offset bits.
    val = 128'hA5A5_0000_1111_2222_3333_4444_5555_0020;
    do_req(32'h0000_0020, val, 1'b1, 0, got, w);
    idle(1);
    do_req(32'h0000_402C, '0, 1'b0, 0, got, w);
    check("alias_data", got, val);
    idle(1);

    // Back-to-back: valid held high, write 0x30 then read 0x40.
    val = 128'hB0B0_0000_0000_0000_0000_0000_0000_0030;
    do_req(32'h0000_0030, val, 1'b1, 0, got, w);
    check("b2b_wr_echo", got, val);
    do_req(32'h0000_0040, 128'hFFFF, 1'b0, 0, got, w);
    check("b2b_spacing", 128'(w), 128'(L + 1));
    check("b2b_rd_data", got, 128'd0);
    idle(1);

    // Mid-flight changes ignored.
    val = 128'hC0C0_1234_5678_9ABC_DEF0_0000_0000_0060;
    do_req(32'h0000_0060, val, 1'b1, 0, got, w);
    idle(1);
    do_req(32'h0000_0060, '0, 1'b0, 1, got, w);
    check("midflight_data", got, val);
    idle(1);

    // Reset during BUSY of a write to 0x50.
    #1;
    req.addr = 32'h0000_0050; req.data = 128'hFEED; req.rw = 1'b1; req.valid = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0; req.valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_ready", {127'd0, resp.ready}, 128'd0);
    end
    do_req(32'h0000_0050, '0, 1'b0, 0, got, w);
    check("rst_discard", got, 128'd0);
    idle(1);

    // Randomized traffic over 16 lines with random alias bits.
    for (int n = 0; n < 60; n++) begin
      a = ($urandom & ~32'h0000_3FF0) | (32'($urandom_range(0, 15)) << 4);
      do_req(a, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
             ($urandom_range(0, 3) == 0), got, w);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    // Stats: 3 reads and 2 writes from a fresh reset.
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      do_req(32'h0000_0070, 128'(i), (i < 2), 0, got, w);
      idle(1);
    end
`ifdef MEM_STATS_EN
    check("stats_rd", {96'd0, rd_count}, 128'd3);
    check("stats_wr", {96'd0, wr_count}, 128'd2);
`else
    check("stats_rd", {96'd0, rd_count}, 128'd0);
    check("stats_wr", {96'd0, wr_count}, 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
